// File: rtl/fft_frame_feeder.sv
// Streams one selected ADC channel into an Avalon-ST FFT sink in FRAME_LEN-sample frames,
// holding the core in reset after rst and waiting for it to unload before the next frame.
module fft_frame_feeder #(
  parameter int NUM_CH     = 4,
  parameter int DW         = 12,
  parameter int FRAME_LEN  = 1024,
  parameter int RST_CYCLES = 100
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_CH*DW-1:0]                          ch_data,
  input  logic [NUM_CH-1:0]                             ch_en,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_sel,
  input  logic                                          single_mode,
  input  logic                                          arm,
  output logic                                          fft_reset_n,
  output logic                                          sink_valid,
  output logic                                          sink_sop,
  output logic                                          sink_eop,
  input  logic                                          sink_ready,
  output logic [DW-1:0]                                 sink_real,
  output logic [DW-1:0]                                 sink_imag,
  output logic [1:0]                                    sink_error,
  input  logic                                          source_valid,
  output logic                                          busy,
  output logic                                          frame_done,
  output logic [15:0]                                   drop_cnt
);
  localparam int SELW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IW   = $clog2(FRAME_LEN);
  localparam int CW   = $clog2(RST_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {RST_HOLD, IDLE, FILL, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            pend_q, pend_d;
  logic            seen_q, seen_d;
  logic [15:0]     drop_q, drop_d;
  logic            vld_q, vld_d, sop_q, sop_d, eop_q, eop_d;
  logic [DW-1:0]   real_q, real_d;
  logic            fd_q, fd_d;
  logic            frst_n_q, frst_n_d;
  logic            en_sel, go;
  logic [DW-1:0]   dat_sel;

  // Selected-channel mux; an out-of-range select reads as a silent channel.
  always_comb begin
    en_sel  = 1'b0;
    dat_sel = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (sel_q == SELW'(k)) begin
        en_sel  = ch_en[k];
        dat_sel = ch_data[k*DW +: DW];
      end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    idx_d    = idx_q;
    pend_d   = pend_q;
    seen_d   = seen_q;
    drop_d   = drop_q;
    frst_n_d = frst_n_q;
    vld_d    = 1'b0;
    sop_d    = 1'b0;
    eop_d    = 1'b0;
    real_d   = '0;
    fd_d     = 1'b0;
    go       = 1'b0;
    case (state_q)
      RST_HOLD: begin
        if (cnt_q == CW'(RST_CYCLES - 1)) begin
          state_d  = IDLE;
          frst_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      IDLE: begin
        go = single_mode ? ((arm | pend_q) & ~source_valid) : ~source_valid;
        if (single_mode && arm) pend_d = 1'b1;
        if (go) begin
          state_d = FILL;
          sel_d   = ch_sel;
          pend_d  = 1'b0;
          seen_d  = 1'b0;
        end
      end
      FILL: begin
        // The eop beat is on the bus this cycle; the frame is closed, so no more sampling.
        if (eop_q) begin
          state_d = DRAIN;
        end else if (en_sel) begin
          if (sink_ready) begin
            vld_d  = 1'b1;
            real_d = dat_sel;
            sop_d  = (idx_q == '0);
            eop_d  = (idx_q == LAST_IDX);
            idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
          end else if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
          end
        end
      end
      DRAIN: begin
        if (source_valid) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          fd_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = RST_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RST_HOLD;
      cnt_q    <= '0;
      sel_q    <= '0;
      idx_q    <= '0;
      pend_q   <= 1'b0;
      seen_q   <= 1'b0;
      drop_q   <= '0;
      frst_n_q <= 1'b0;
      vld_q    <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      real_q   <= '0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      seen_q   <= seen_d;
      drop_q   <= drop_d;
      frst_n_q <= frst_n_d;
      vld_q    <= vld_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      real_q   <= real_d;
      fd_q     <= fd_d;
    end
  end

  assign fft_reset_n = frst_n_q;
  assign sink_valid  = vld_q;
  assign sink_sop    = sop_q;
  assign sink_eop    = eop_q;
  assign sink_real   = real_q;
  assign sink_imag   = '0;
  assign sink_error  = '0;
  assign busy        = (state_q != IDLE);
  assign frame_done  = fd_q;
  assign drop_cnt    = drop_q;
endmodule
